// File: rtl/uart_frame_loader.sv
// Parses SYNC/LEN_HI/LEN_LO/pixels/CHK uploads from the UART RX FIFO into frame buffer writes.
// Latency: pixel write, done and error pulses appear one cycle after the byte that causes them.
// Backpressure: none offered; a byte is popped every cycle the FIFO is non-empty and reset is low.
module uart_frame_loader #(
    parameter int          ADDR_W         = 14,
    parameter int          MAX_PIXELS     = 16384,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    input  logic              rx_empty,
    input  logic [7:0]        read_data,
    output logic              read_uart,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   pix_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_PIX,
        S_CHK
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [7:0]          sum_q, sum_d;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [1:0]          err_code_q, err_code_d;
    logic [ADDR_W:0]     pix_count_q, pix_count_d;

    logic                accept;
    logic [15:0]         len_full;

    // Pop whenever a byte is available; reset blocks the pop so nothing is lost.
    assign accept    = ~rx_empty & ~reset;
    assign read_uart = accept;
    assign len_full  = {len_q[15:8], read_data};

    // Next-state logic: byte parsing plus the inter-byte timeout (an accepted byte wins over expiry).
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        tmr_d       = tmr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        pix_count_d = pix_count_q;

        if (state_q != S_IDLE) begin
            if (accept) begin
                tmr_d = '0;
            end else if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
                tmr_d      = '0;
                state_d    = S_IDLE;
                err_d      = 1'b1;
                err_code_d = 2'b11;
            end else begin
                tmr_d = tmr_q + 1'b1;
            end
        end

        if (accept) begin
            case (state_q)
                S_IDLE: begin
                    if (read_data == SYNC_BYTE) begin
                        state_d = S_LEN_HI;
                        tmr_d   = '0;
                    end
                end
                S_LEN_HI: begin
                    len_d   = {read_data, 8'h00};
                    state_d = S_LEN_LO;
                end
                S_LEN_LO: begin
                    len_d = len_full;
                    cnt_d = '0;
                    sum_d = 8'h00;
                    if (len_full > 16'(MAX_PIXELS)) begin
                        state_d    = S_IDLE;
                        err_d      = 1'b1;
                        err_code_d = 2'b10;
                    end else if (len_full == 16'h0000) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_PIX;
                    end
                end
                S_PIX: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = read_data;
                    sum_d     = sum_q + read_data;
                    cnt_d     = cnt_q + 1'b1;
                    if (16'(cnt_q) + 16'd1 == len_q) begin
                        state_d = S_CHK;
                    end
                end
                S_CHK: begin
                    state_d = S_IDLE;
                    if (read_data == sum_q) begin
                        done_d      = 1'b1;
                        pix_count_d = len_q[ADDR_W:0];
                        err_code_d  = 2'b00;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = 2'b01;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and registered outputs; reset discards any partial frame without a pulse.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            tmr_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            pix_count_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            tmr_q       <= tmr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            pix_count_q <= pix_count_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign err_code   = err_code_q;
    assign pix_count  = pix_count_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Bench for uart_frame_loader: frames are built at byte level and expected outputs follow from their contents.
// Latency: each driven byte's effect is expected on the outputs right after the edge that pops it.
// Backpressure: the DUT never stalls, so every driven byte is a pop unless reset is high.
module tb_uart_frame_loader;

    localparam int AW   = 14;
    localparam int MAXP = 16384;
    localparam int T    = 200;

    logic          clk_100MHz = 1'b0;
    logic          reset;
    logic          rx_empty;
    logic [7:0]    read_data;
    logic          read_uart;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          busy;
    logic          frame_done;
    logic          frame_err;
    logic [1:0]    err_code;
    logic [AW:0]   pix_count;

    always #5 clk_100MHz = ~clk_100MHz;

    uart_frame_loader #(
        .ADDR_W(AW), .MAX_PIXELS(MAXP), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_100MHz(clk_100MHz), .reset(reset), .rx_empty(rx_empty), .read_data(read_data),
        .read_uart(read_uart), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .frame_done(frame_done), .frame_err(frame_err),
        .err_code(err_code), .pix_count(pix_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Expected effect of the byte driven in the current step (pulses) and sticky output values.
    logic          e_wr, e_done, e_err, e_zero, e_busy;
    logic [AW-1:0] e_addr;
    logic [7:0]    e_data;
    logic [1:0]    e_code;
    logic [AW:0]   e_pix;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of input, then compare every output against the expectations.
    task automatic step(input bit v, input logic [7:0] b, input bit rst);
        reset     = rst;
        rx_empty  = ~v;
        read_data = b;
        #1;
        chk("read_uart", read_uart, v & ~rst);
        @(posedge clk_100MHz);
        cyc++;
        @(negedge clk_100MHz);
        chk("wr_en", wr_en, e_wr);
        if (e_wr) begin
            chk("wr_addr", wr_addr, e_addr);
            chk("wr_data", wr_data, e_data);
        end
        if (e_zero) begin
            chk("rst_wr_addr", wr_addr, 0);
            chk("rst_wr_data", wr_data, 0);
        end
        chk("frame_done", frame_done, e_done);
        chk("frame_err", frame_err, e_err);
        chk("busy", busy, e_busy);
        chk("err_code", err_code, e_code);
        chk("pix_count", pix_count, e_pix);
        e_wr = 1'b0; e_done = 1'b0; e_err = 1'b0; e_zero = 1'b0;
    endtask

    task automatic do_reset();
        e_busy = 1'b0; e_code = 2'b00; e_pix = '0; e_zero = 1'b1;
        step(1'b1, 8'($urandom), 1'b1);
    endtask

    task automatic junk(input int n);
        logic [7:0] b;
        for (int k = 0; k < n; k++) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h5A;
            if ($urandom_range(0, 1) == 0) step(1'b0, b, 1'b0);
            step(1'b1, b, 1'b0);
        end
    endtask

    // Fixed frame A5 00 04 10 20 30 40 <c>; good selects whether <c> is the correct sum (A0).
    task automatic lit_frame(input logic [7:0] c, input bit good);
        logic [7:0] px [4];
        px = '{8'h10, 8'h20, 8'h30, 8'h40};
        e_busy = 1'b1;
        step(1'b1, 8'hA5, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h04, 1'b0);
        for (int k = 0; k < 4; k++) begin
            e_wr = 1'b1; e_addr = AW'(k); e_data = px[k];
            step(1'b1, px[k], 1'b0);
        end
        e_busy = 1'b0;
        if (good) begin e_done = 1'b1; e_pix = 15'd4; e_code = 2'b00; end
        else      begin e_err  = 1'b1; e_code = 2'b01; end
        step(1'b1, c, 1'b0);
    endtask

    // abort_mode: 0 none, 1 timeout before byte abort_idx, 2 reset before byte abort_idx.
    // gap_mode: 0 back-to-back bytes, 1 random gaps (sometimes T-1), 2 always T-1.
    task automatic send_frame(input int len, input bit bad, input int abort_mode,
                              input int abort_idx, input int gap_mode);
        logic [7:0] q[$];
        logic [7:0] sum;
        logic [7:0] p;
        int         n;
        sum = 8'h00;
        p = len[15:8]; q.push_back(p);
        p = len[7:0];  q.push_back(p);
        if (len <= MAXP) begin
            for (int k = 0; k < len; k++) begin
                p = 8'($urandom);
                q.push_back(p);
                sum = sum + p;
            end
            p = bad ? sum + 8'($urandom_range(1, 255)) : sum;
            q.push_back(p);
        end
        e_busy = 1'b1;
        step(1'b1, 8'hA5, 1'b0);
        for (int i = 0; i < q.size(); i++) begin
            if (abort_mode == 1 && i == abort_idx) begin
                repeat (T - 1) step(1'b0, 8'($urandom), 1'b0);
                e_err = 1'b1; e_code = 2'b11; e_busy = 1'b0;
                step(1'b0, 8'($urandom), 1'b0);
                return;
            end
            if (abort_mode == 2 && i == abort_idx) begin
                do_reset();
                return;
            end
            if (gap_mode == 2) n = T - 1;
            else if (gap_mode == 1) n = ($urandom_range(0, 15) == 0) ? T - 1 : int'($urandom_range(0, 3));
            else n = 0;
            repeat (n) step(1'b0, 8'($urandom), 1'b0);
            if (i == 1 && len > MAXP) begin
                e_err = 1'b1; e_code = 2'b10; e_busy = 1'b0;
                step(1'b1, q[i], 1'b0);
                return;
            end
            if (i >= 2 && i < len + 2) begin
                e_wr = 1'b1; e_addr = AW'(i - 2); e_data = q[i];
            end
            if (i == len + 2) begin
                e_busy = 1'b0;
                if (!bad) begin e_done = 1'b1; e_pix = (AW + 1)'(len); e_code = 2'b00; end
                else      begin e_err  = 1'b1; e_code = 2'b01; end
            end
            step(1'b1, q[i], 1'b0);
        end
    endtask

    initial begin
        int sel, len;
        reset = 1'b1; rx_empty = 1'b1; read_data = 8'h00;
        e_wr = 0; e_done = 0; e_err = 0; e_zero = 0; e_busy = 0;
        e_addr = '0; e_data = '0; e_code = 2'b00; e_pix = '0;
        @(negedge clk_100MHz);

        // Reset state, including a byte presented while reset is high.
        e_zero = 1'b1; step(1'b0, 8'h00, 1'b1);
        e_zero = 1'b1; step(1'b1, 8'hA5, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Good 4-pixel frame, then the same frame with a bad checksum.
        lit_frame(8'hA0, 1'b1);
        chk("t1_pix_count", pix_count, 15'd4);
        step(1'b0, 8'h00, 1'b0);
        lit_frame(8'hA1, 1'b0);
        chk("t2_err_code", err_code, 2'b01);
        chk("t2_pix_kept", pix_count, 15'd4);

        // LEN = 16385 rejected right after LEN_LO; LEN = 16384 accepted.
        send_frame(16385, 1'b0, 0, 0, 0);
        chk("t3_err_code", err_code, 2'b10);
        send_frame(MAXP, 1'b0, 0, 0, 0);
        chk("t3_max_pix", pix_count, 15'd16384);

        // Junk dropped, then a zero-length frame (sum of nothing is 00).
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        step(1'b1, 8'h5A, 1'b0);
        e_busy = 1'b1;
        step(1'b1, 8'hA5, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        e_busy = 1'b0; e_done = 1'b1; e_pix = '0; e_code = 2'b00;
        step(1'b1, 8'h00, 1'b0);
        chk("t4_pix_zero", pix_count, 15'd0);

        // Timeout after one pixel of a 2-pixel frame, then a normal frame.
        send_frame(2, 1'b0, 1, 3, 0);
        chk("t5_err_code", err_code, 2'b11);
        send_frame(3, 1'b0, 0, 0, 1);
        // Gaps of exactly T-1 never time out; timeout straight after SYNC.
        send_frame(3, 1'b0, 0, 0, 2);
        send_frame(5, 1'b0, 1, 0, 0);

        // Reset after the 2nd pixel, then a full frame.
        send_frame(4, 1'b0, 2, 4, 0);
        chk("t6_busy", busy, 1'b0);
        send_frame(6, 1'b0, 0, 0, 0);
        send_frame(2, 1'b1, 0, 0, 0);
        send_frame(1, 1'b0, 0, 0, 0);

        // Randomized mix of frames, junk, errors, timeouts and resets.
        for (int r = 0; r < 40; r++) begin
            junk(int'($urandom_range(0, 3)));
            sel = int'($urandom_range(0, 9));
            len = int'($urandom_range(0, 20));
            if (sel == 0)      send_frame(int'($urandom_range(MAXP + 1, 65535)), 1'b0, 0, 0, 1);
            else if (sel == 1) send_frame(len, 1'b0, 1, int'($urandom_range(0, len + 2)), 1);
            else if (sel == 2) send_frame(len, 1'b0, 2, int'($urandom_range(0, len + 2)), 1);
            else               send_frame(len, ($urandom_range(0, 3) == 0), 0, 0, 1);
        end
        step(1'b0, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
